// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the iterative mul/div engine.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: one result bit per cycle on magnitudes,
// followed by a single sign-fixup cycle that presents HI/LO to the top level.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wr_o,
    output logic [WIDTH-1:0] hi_res_o,
    output logic [WIDTH-1:0] lo_res_o
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, mq_q, opnd_q;
    logic             is_div_q, neg_res_q, neg_rem_q, div0_q, done_q;

    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] acc_d, mq_d;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign a_neg     = is_signed & a_i[WIDTH-1];
    assign b_neg     = is_signed & b_i[WIDTH-1];
    assign a_abs     = a_neg ? -a_i : a_i;
    assign b_abs     = b_neg ? -b_i : b_i;

    // Multiplier sits in mq and shifts out LSB-first; dividend shifts out MSB-first.
    assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        acc_d = acc_q;
        mq_d  = mq_q;
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_d = div_diff[WIDTH-1:0];
                mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_shift[WIDTH-1:0];
                mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
        end
    end

    assign prod     = {acc_q, mq_q};
    assign prod_fix = neg_res_q ? -prod : prod;

    always_comb begin
        hi_res_o = prod_fix[2*WIDTH-1:WIDTH];
        lo_res_o = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            hi_res_o = neg_rem_q ? -acc_q : acc_q;
            lo_res_o = div0_q ? '1 : (neg_res_q ? -mq_q : mq_q);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: if (start_i) begin
                    state_q   <= MD_CALC;
                    cnt_q     <= CW'(WIDTH - 1);
                    is_div_q  <= op_i[1];
                    acc_q     <= '0;
                    mq_q      <= a_abs;
                    opnd_q    <= b_abs;
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    div0_q    <= (b_i == '0);
                end
                MD_CALC: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) state_q <= MD_FIX;
                end
                MD_FIX: begin
                    state_q <= MD_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != MD_IDLE);
    assign wr_o   = (state_q == MD_FIX);
    assign done_o = done_q;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle combinational ops plus HI/LO registers fed
// by the iterative mul/div engine or by MTHI/MTLO while the engine is idle.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       ALU_Ctr,
    input  logic             alu_sign,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic             md_busy,
    output logic             md_done,
    input  logic [1:0]       hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] sum, diff, hi_res, lo_res, hi_q, lo_q;
    logic             add_ovf, sub_ovf, md_wr;

    assign sum     = A + B;
    assign diff    = A - B;
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    // Shifts operate on rt (B), as in the MIPS sll/srl/sra encodings.
    always_comb begin
        res      = '0;
        overflow = 1'b0;
        case (ALU_Ctr)
            ALU_AND:  res = A & B;
            ALU_OR:   res = A | B;
            ALU_ADD:  begin res = sum;  overflow = alu_sign & add_ovf; end
            ALU_SUB:  begin res = diff; overflow = alu_sign & sub_ovf; end
            ALU_NOR:  res = ~(A | B);
            ALU_XOR:  res = A ^ B;
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SRL:  res = B >> shamt;
            ALU_SLL:  res = B << shamt;
            ALU_SRA:  res = $signed(B) >>> shamt;
            default:  res = '0;
        endcase
    end

    assign zero = (res == '0);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .op_i     (md_op),
        .a_i      (A),
        .b_i      (B),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .wr_o     (md_wr),
        .hi_res_o (hi_res),
        .lo_res_o (lo_res)
    );

    // The engine's FIX cycle is itself busy, so it never competes with MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_wr) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
        end else if (!md_busy) begin
            if (hilo_we[1]) hi_q <= A;
            if (hilo_we[0]) lo_q <= A;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
